// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, function codes, FSM states, datapath select values.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_defs;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // FSM state encodings; the numeric values are visible on the debug port
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    // Instruction classes produced by mc_decode
    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH,
        C_JUMP, C_JAL, C_JR, C_NOP, C_ILLEGAL
    } iclass_e;

    // Register write address select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Register write data select
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_DM  = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    // Next-PC source
    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

endpackage

// File: rtl/mc_decode.sv
// Classifies the latched opcode/funct pair into an instruction class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_e    cls_o
);

    // Only Op and funct are visible here, so an R-type word with funct=sll is
    // treated as the all-zero NOP; any other undecoded pattern is illegal.
    always_comb begin
        cls_o = C_ILLEGAL;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU, FN_SUBU: cls_o = C_RTYPE;
                    FN_JR:            cls_o = C_JR;
                    FN_SLL:           cls_o = C_NOP;
                    default:          cls_o = C_ILLEGAL;
                endcase
            end
            OP_ORI, OP_LUI: cls_o = C_IMM;
            OP_LW:          cls_o = C_LOAD;
            OP_SW:          cls_o = C_STORE;
            OP_BEQ:         cls_o = C_BRANCH;
            OP_J:           cls_o = C_JUMP;
            OP_JAL:         cls_o = C_JAL;
            default:        cls_o = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB/HALT sequencing of datapath strobes.
// Latency: 2..5 cycles per instruction plus MEM_LAT per memory phase; outputs decoded from state.
// Backpressure: none; memory wait is a fixed MEM_LAT-cycle stretch of FETCH and MEM.
module mc_controller
    import mips_defs::*;
#(
    parameter int unsigned MEM_LAT      = 0,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PC_We,
    output logic       IR_We,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic [1:0] RegDst,
    output logic [1:0] Mem2Reg,
    output logic [1:0] ExtOp,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] nPC_Sel,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    iclass_e    cls;
    logic       mem_done;

    logic       pc_we_c, ir_we_c, reg_write_c, mem_write_c, mem_read_c, retire_c;
    logic [1:0] reg_dst_c, mem2reg_c, ext_op_c;
    logic       alu_src_c;
    logic [2:0] alu_op_c, npc_sel_c;

    mc_decode u_decode (
        .op_i    (Op),
        .funct_i (funct),
        .cls_o   (cls)
    );

    // With MEM_LAT=0 every memory phase is a single cycle and the counter is ignored.
    assign mem_done = (LAT == 3'd0) || (cnt_q == LAT);

    // State, wait counter and sticky illegal flag; reset is synchronous and overrides all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, counter and raw control decode from the registered state and Op/funct.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        pc_we_c     = 1'b0;
        ir_we_c     = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        mem_read_c  = 1'b0;
        retire_c    = 1'b0;
        reg_dst_c   = REGDST_RT;
        mem2reg_c   = M2R_ALU;
        ext_op_c    = EXT_ZERO;
        alu_src_c   = 1'b0;
        alu_op_c    = ALU_ADD;
        npc_sel_c   = NPC_SEQ;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_done) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_JUMP: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = NPC_J;
                        retire_c  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JAL: begin
                        pc_we_c     = 1'b1;
                        npc_sel_c   = NPC_J;
                        reg_write_c = 1'b1;
                        reg_dst_c   = REGDST_RA;
                        mem2reg_c   = M2R_PC4;
                        retire_c    = 1'b1;
                        state_d     = S_FETCH;
                    end
                    C_JR: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = NPC_JR;
                        retire_c  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_NOP: begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_ILLEGAL: begin
                        illegal_d = 1'b1;
                        if (TRAP_ILLEGAL) begin
                            state_d = S_HALT;
                        end else begin
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls)
                    C_BRANCH: begin
                        alu_op_c = ALU_SUB;
                        ext_op_c = EXT_SIGN;
                        if (zero) begin
                            pc_we_c   = 1'b1;
                            npc_sel_c = NPC_BR;
                        end
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALU_ADD;
                        ext_op_c  = EXT_SIGN;
                        state_d   = S_MEM;
                    end
                    C_RTYPE: begin
                        alu_op_c = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                        state_d  = S_WB;
                    end
                    C_IMM: begin
                        alu_src_c = 1'b1;
                        if (Op == OP_LUI) begin
                            ext_op_c = EXT_UPPER;
                            alu_op_c = ALU_ADD;
                        end else begin
                            ext_op_c = EXT_ZERO;
                            alu_op_c = ALU_OR;
                        end
                        state_d = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read_c = (cls == C_LOAD);
                if (mem_done) begin
                    if (cls == C_STORE) begin
                        mem_write_c = 1'b1;
                        retire_c    = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = (cls == C_RTYPE) ? REGDST_RD : REGDST_RT;
                mem2reg_c   = (cls == C_LOAD) ? M2R_DM : M2R_ALU;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Every memory phase starts its wait count from zero.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            cnt_d = 3'd0;
        end
    end

    // Strobes and selects are held low while reset is asserted so a reset
    // cycle can never write PC, IR, the register file or memory.
    assign PC_We    = pc_we_c     & ~reset;
    assign IR_We    = ir_we_c     & ~reset;
    assign RegWrite = reg_write_c & ~reset;
    assign MemWrite = mem_write_c & ~reset;
    assign MemRead  = mem_read_c  & ~reset;
    assign retire   = retire_c    & ~reset;
    assign RegDst   = reset ? REGDST_RT : reg_dst_c;
    assign Mem2Reg  = reset ? M2R_ALU   : mem2reg_c;
    assign ExtOp    = reset ? EXT_ZERO  : ext_op_c;
    assign ALUSrc   = alu_src_c & ~reset;
    assign ALUOp    = reset ? ALU_ADD   : alu_op_c;
    assign nPC_Sel  = reset ? NPC_SEQ   : npc_sel_c;
    assign state    = state_q;
    assign illegal  = illegal_q;

endmodule
